// File: rtl/rvc_asap_5pl_dmem_arb_if.sv
// Requester-side bundle for the data-memory arbiter: one instance per requester.
// The requester drives the access attributes; the arbiter returns grant and read data.
interface rvc_asap_5pl_dmem_arb_if;
    logic        req;
    logic        wren;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  byte_en;
    logic        gnt;
    logic        rd_valid;
    logic [31:0] rd_data;

    modport master (
        output req, wren, addr, data, byte_en,
        input  gnt, rd_valid, rd_data
    );

    modport slave (
        input  req, wren, addr, data, byte_en,
        output gnt, rd_valid, rd_data
    );
endinterface

// File: rtl/rvc_asap_5pl_dmem_arb.sv
// Core/external arbiter for the shared synchronous-read data memory port.
// Optional starvation guard for the external requester: define RVC_DMEM_ARB_STARVE_GUARD_EN.
module rvc_asap_5pl_dmem_arb #(
    parameter int MAX_WAIT = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    rvc_asap_5pl_dmem_arb_if.slave        core_if,
    rvc_asap_5pl_dmem_arb_if.slave        ext_if,
    output logic [31:0]                   o_data,
    output logic [31:0]                   o_address,
    output logic [3:0]                    o_byteena,
    output logic                          o_wren,
    output logic                          o_rden,
    input  logic [31:0]                   i_q
);

    typedef enum logic {
        CORE_PRI  = 1'b0,
        EXT_BOOST = 1'b1
    } arb_state_e;

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("rvc_asap_5pl_dmem_arb: MAX_WAIT must lie in 1..15");
    end

    arb_state_e  w_state;
    logic        w_core_gnt;
    logic        w_ext_gnt;
    logic        w_wr_sel;
    logic        w_rden;
    logic        w_wren;
    logic [31:0] w_address;

    logic        r_rd_pend;
    logic        r_rd_owner;

`ifdef RVC_DMEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    arb_state_e  r_state;
    arb_state_e  w_state_next;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  w_wait_cnt_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= CORE_PRI;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    // The boost decision looks at the registered count, so an Ext request that
    // drops in the same cycle the count saturates never enters EXT_BOOST.
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;

        if (!ext_if.req || w_ext_gnt) begin
            w_wait_cnt_next = '0;
        end else if (r_wait_cnt != MAX_WAIT_C) begin
            w_wait_cnt_next = r_wait_cnt + 4'd1;
        end

        case (r_state)
            CORE_PRI: begin
                if (ext_if.req && !w_ext_gnt && (r_wait_cnt == MAX_WAIT_C)) begin
                    w_state_next = EXT_BOOST;
                end
            end
            EXT_BOOST: begin
                if (w_ext_gnt || !ext_if.req) begin
                    w_state_next = CORE_PRI;
                end
            end
            default: w_state_next = CORE_PRI;
        endcase
    end

    assign w_state = r_state;
`else
    assign w_state = CORE_PRI;
`endif

    // Grant is purely combinational from the requests and the priority state.
    always_comb begin
        w_core_gnt = 1'b0;
        w_ext_gnt  = 1'b0;
        if (!i_rst) begin
            if (ext_if.req && ((w_state == EXT_BOOST) || !core_if.req)) begin
                w_ext_gnt = 1'b1;
            end else if (core_if.req) begin
                w_core_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        w_wr_sel  = 1'b0;
        w_address = '0;
        if (w_core_gnt) begin
            w_wr_sel  = core_if.wren;
            w_address = core_if.addr;
        end else if (w_ext_gnt) begin
            w_wr_sel  = ext_if.wren;
            w_address = ext_if.addr;
        end
    end

    assign w_wren    = (w_core_gnt || w_ext_gnt) && w_wr_sel;
    assign w_rden    = (w_core_gnt || w_ext_gnt) && !w_wr_sel;
    assign o_wren    = w_wren;
    assign o_rden    = w_rden;
    assign o_address = w_address;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        always_comb begin
            o_data[8*gi +: 8] = 8'h00;
            o_byteena[gi]     = 1'b0;
            if (w_core_gnt) begin
                o_data[8*gi +: 8] = core_if.data[8*gi +: 8];
                o_byteena[gi]     = core_if.byte_en[gi];
            end else if (w_ext_gnt) begin
                o_data[8*gi +: 8] = ext_if.data[8*gi +: 8];
                o_byteena[gi]     = ext_if.byte_en[gi];
            end
        end
    end

    // Owner only moves on a granted read; writes leave an in-flight return alone.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
        end else begin
            r_rd_pend <= w_rden;
            if (w_rden) begin
                r_rd_owner <= w_ext_gnt;
            end
        end
    end

    // A read issued just before reset rises is suppressed rather than returned.
    assign core_if.gnt      = w_core_gnt;
    assign ext_if.gnt       = w_ext_gnt;
    assign core_if.rd_valid = r_rd_pend && !r_rd_owner && !i_rst;
    assign ext_if.rd_valid  = r_rd_pend &&  r_rd_owner && !i_rst;
    assign core_if.rd_data  = i_q;
    assign ext_if.rd_data   = i_q;

endmodule

// File: tb/tb_rvc_asap_5pl_dmem_arb.sv
// Bench for rvc_asap_5pl_dmem_arb: directed scenarios then randomized traffic,
// checked every cycle against a priority/wait-time model and a reference memory.
module tb_rvc_asap_5pl_dmem_arb;
    localparam int MAXW = 4;
`ifdef RVC_DMEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rvc_asap_5pl_dmem_arb_if core_if ();
    rvc_asap_5pl_dmem_arb_if ext_if ();

    logic [31:0] mem_data;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic        mem_wren;
    logic        mem_rden;
    logic [31:0] mem_q;

    rvc_asap_5pl_dmem_arb #(.MAX_WAIT(MAXW)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .core_if   (core_if.slave),
        .ext_if    (ext_if.slave),
        .o_data    (mem_data),
        .o_address (mem_addr),
        .o_byteena (mem_be),
        .o_wren    (mem_wren),
        .o_rden    (mem_rden),
        .i_q       (mem_q)
    );

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h0101_0101) ^ 32'h5A00_C300;
    endfunction

    // Memory the arbiter talks to; q is garbage unless a read was issued.
    logic [31:0] env_mem [256];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
            mem_q <= 32'hDEAD_BEEF;
        end else begin
            mem_q <= mem_rden ? env_mem[mem_addr[9:2]] : $urandom;
            if (mem_wren)
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) env_mem[mem_addr[9:2]][8*b +: 8] <= mem_data[8*b +: 8];
        end
    end

    int          checks   = 0;
    int          failures = 0;
    int          denied   = 0;    // consecutive cycles Ext has been waiting
    bit          pend     = 1'b0;
    bit          pend_ext = 1'b0;
    logic [31:0] pend_data;
    logic [31:0] ref_mem [256];
    bit          last_cg, last_eg, obs_cg, obs_eg, obs_cv, obs_ev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Called 1 time unit after a rising edge with inputs already applied.
    task automatic run_cycle();
        bit          boost, cg, eg, wr, cv, ev;
        logic [31:0] a, d;
        logic [3:0]  be;
        #2;
        boost = GUARD && (denied > MAXW);
        eg    = !rst && ext_if.req && (!core_if.req || boost);
        cg    = !rst && core_if.req && !eg;
        a  = cg ? core_if.addr    : eg ? ext_if.addr    : 32'h0;
        d  = cg ? core_if.data    : eg ? ext_if.data    : 32'h0;
        be = cg ? core_if.byte_en : eg ? ext_if.byte_en : 4'h0;
        wr = cg ? core_if.wren    : eg ? ext_if.wren    : 1'b0;
        cv = !rst && pend && !pend_ext;
        ev = !rst && pend &&  pend_ext;
        obs_cg = core_if.gnt;
        obs_eg = ext_if.gnt;
        obs_cv = core_if.rd_valid;
        obs_ev = ext_if.rd_valid;
        check("core_gnt", 32'(core_if.gnt), 32'(cg));
        check("ext_gnt", 32'(ext_if.gnt), 32'(eg));
        check("address", mem_addr, a);
        check("data", mem_data, d);
        check("byteena", 32'(mem_be), 32'(be));
        check("wren", 32'(mem_wren), 32'((cg || eg) && wr));
        check("rden", 32'(mem_rden), 32'((cg || eg) && !wr));
        check("core_rd_valid", 32'(core_if.rd_valid), 32'(cv));
        check("ext_rd_valid", 32'(ext_if.rd_valid), 32'(ev));
        check("valid_overlap", 32'(core_if.rd_valid & ext_if.rd_valid), 32'h0);
        if (cv) check("core_rd_data", core_if.rd_data, pend_data);
        if (ev) check("ext_rd_data", ext_if.rd_data, pend_data);
        if (cg || eg)
            $display("t=%0t %s %s addr=%h data=%h be=%h", $time, cg ? "CORE" : "EXT ",
                     wr ? "WR" : "RD", a, wr ? d : ref_mem[a[9:2]], be);
        if (rst) begin
            denied = 0;
            pend   = 1'b0;
            for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        end else begin
            pend = (cg || eg) && !wr;
            if (pend) begin
                pend_ext  = eg;
                pend_data = ref_mem[a[9:2]];
            end
            if ((cg || eg) && wr)
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
            denied = (eg || !ext_if.req) ? 0 : ((denied < 1000) ? denied + 1 : denied);
        end
        last_cg = cg;
        last_eg = eg;
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input bit req, input bit wr, input logic [31:0] a, input logic [31:0] d);
        core_if.req = req; core_if.wren = wr; core_if.addr = a; core_if.data = d; core_if.byte_en = 4'hF;
    endtask

    task automatic set_ext(input bit req, input bit wr, input logic [31:0] a, input logic [31:0] d);
        ext_if.req = req; ext_if.wren = wr; ext_if.addr = a; ext_if.data = d; ext_if.byte_en = 4'hF;
    endtask

    initial begin
        int first;
        int busy;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        pend_data = 32'h0;

        // Reset with both requesting, then the contended read/write on release.
        rst = 1'b1;
        set_core(1'b1, 1'b0, 32'h0000_1004, 32'h0);
        set_ext (1'b1, 1'b1, 32'h0000_1008, 32'hCAFE_F00D);
        run_cycle();
        run_cycle();
        rst = 1'b0;
        run_cycle();
        check("rst_release_core_gnt", 32'(obs_cg), 32'h1);
        core_if.req = 1'b0;
        run_cycle();
        check("contend_ext_wr_gnt", 32'(obs_eg), 32'h1);
        check("contend_core_rd_valid", 32'(obs_cv), 32'h1);
        ext_if.req = 1'b0;
        run_cycle();

        // Continuous core reads against a pending Ext read.
        set_core(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        set_ext (1'b1, 1'b0, 32'h0000_2010, 32'h0);
        first = 0;
        for (int k = 1; k <= 50; k++) begin
            if (last_cg) core_if.addr = $urandom & 32'h0000_03FC;
            run_cycle();
            if (obs_eg) begin
                first = k;
                break;
            end
        end
        check("ext_first_gnt_cycle", 32'(first), GUARD ? 32'd6 : 32'd0);
        if (first == 0) begin
            core_if.req = 1'b0;
            run_cycle();
            check("ext_gnt_core_idle", 32'(obs_eg), 32'h1);
        end
        ext_if.req   = 1'b0;
        core_if.req  = 1'b1;
        core_if.addr = 32'h0000_0080;
        run_cycle();
        check("core_gnt_after_ext", 32'(obs_cg), 32'h1);
        check("ext_rd_valid_after_gnt", 32'(obs_ev), 32'h1);
        core_if.req = 1'b0;
        run_cycle();

        // Back-to-back reads from different owners.
        set_core(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        run_cycle();
        set_core(1'b0, 1'b0, 32'h0000_0010, 32'h0);
        set_ext (1'b1, 1'b0, 32'h0000_0020, 32'h0);
        run_cycle();
        check("pipe_core_valid", 32'(obs_cv), 32'h1);
        ext_if.req = 1'b0;
        run_cycle();
        check("pipe_ext_valid", 32'(obs_ev), 32'h1);
        run_cycle();

        // Ext read followed immediately by reset: its return is dropped.
        set_ext(1'b1, 1'b0, 32'h0000_0030, 32'h0);
        run_cycle();
        rst = 1'b1;
        ext_if.req = 1'b0;
        run_cycle();
        check("rst_drop_ext_valid", 32'(obs_ev), 32'h0);
        rst = 1'b0;
        run_cycle();
        check("after_rst_ext_valid", 32'(obs_ev), 32'h0);

        // Randomized traffic with alternating load levels and sparse resets.
        for (int n = 0; n < 2000; n++) begin
            busy = ((n / 250) % 2 == 1) ? 95 : 60;
            rst  = ($urandom_range(0, 149) == 0);
            if (!core_if.req || last_cg) begin
                core_if.req     = ($urandom_range(0, 99) < busy);
                core_if.wren    = ($urandom_range(0, 2) == 0);
                core_if.addr    = $urandom & 32'hFFFF_FFFC;
                core_if.data    = $urandom;
                core_if.byte_en = 4'($urandom);
            end
            if (!ext_if.req || last_eg) begin
                ext_if.req     = ($urandom_range(0, 99) < 40);
                ext_if.wren    = ($urandom_range(0, 1) == 0);
                ext_if.addr    = $urandom & 32'hFFFF_FFFC;
                ext_if.data    = $urandom;
                ext_if.byte_en = 4'($urandom);
            end
            run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
